// File: rtl/pong_input_conditioner_if.sv
// Button-side bus of the pong input conditioner: raw buttons in, clean
// levels, press pulses, the paddle direction code and a debug view of the
// three debounce state machines out.
//
// There is no valid/ready handshake on this bus. The raw inputs are free
// running and asynchronous to clk. Every output is a plain level, valid on
// every clock cycle. The pulse outputs are high for exactly one cycle per
// event.
interface pong_input_conditioner_if;
    logic       right_raw;
    logic       left_raw;
    logic       ready_raw;
    logic       right_level;
    logic       left_level;
    logic       ready_level;
    logic       right_pulse;
    logic       left_pulse;
    logic       ready_pulse;
    logic [1:0] move_dir;
    logic [5:0] dbg_state;   // {ready, left, right} debounce FSM states

    // Button / game side: drives the raw buttons, consumes the results.
    modport master (
        output right_raw, left_raw, ready_raw,
        input  right_level, left_level, ready_level,
        input  right_pulse, left_pulse, ready_pulse,
        input  move_dir, dbg_state
    );

    // Conditioner side.
    modport slave (
        input  right_raw, left_raw, ready_raw,
        output right_level, left_level, ready_level,
        output right_pulse, left_pulse, ready_pulse,
        output move_dir, dbg_state
    );
endinterface

// File: rtl/pong_input_conditioner.sv
// Input front end for pong: synchronise, debounce and polarity-normalise
// the right/left/ready buttons, then produce clean levels, press pulses
// (with auto-repeat on right/left) and the resolved paddle direction.
// Channel index: 0 = right, 1 = left, 2 = ready.
module pong_input_conditioner #(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int REPEAT_DELAY     = 25000000,
    parameter int REPEAT_PERIOD    = 5000000,
    parameter bit INPUT_ACTIVE_LOW = 1'b1,
    parameter int CNT_W            = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    pong_input_conditioner_if.slave  bus
);

    typedef enum logic [1:0] {
        REL    = 2'd0,
        WAIT_P = 2'd1,
        PRS    = 2'd2,
        WAIT_R = 2'd3
    } db_state_e;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    // Raw level of a released button; the sync flops reset to it so that
    // a button held through reset is seen as a fresh press afterwards.
    localparam logic [2:0]       RAW_IDLE = INPUT_ACTIVE_LOW ? 3'b111 : 3'b000;

    logic [2:0]       raw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       s;
    db_state_e        state_q   [3];
    logic [CNT_W-1:0] db_cnt_q  [3];
    logic [2:0]       level_d;
    logic [2:0]       level_q;
    logic [2:0]       press;
    logic [2:0]       pulse_q;
    logic [1:0]       other_q;
    logic [1:0]       rep_active;
    logic [1:0]       rep_fire;
    logic [CNT_W-1:0] rep_cnt_q [2];
    logic [1:0]       rep_armed_q;

    assign raw = {bus.ready_raw, bus.left_raw, bus.right_raw};

    // Two-flop synchroniser per button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RAW_IDLE;
            sync2_q <= RAW_IDLE;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Polarity is normalised after the second flop: s = 1 means pressed.
    assign s = INPUT_ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Debounce FSMs: a level change needs DEBOUNCE_CYCLES consecutive
    // samples of the new value; any contrary sample restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 3; c++) begin
                state_q[c]  <= REL;
                db_cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                case (state_q[c])
                    REL: begin
                        if (s[c]) begin
                            state_q[c]  <= WAIT_P;
                            db_cnt_q[c] <= ONE;
                        end
                    end
                    WAIT_P: begin
                        if (!s[c]) begin
                            state_q[c]  <= REL;
                            db_cnt_q[c] <= '0;
                        end else if (db_cnt_q[c] == DB_LAST) begin
                            state_q[c]  <= PRS;
                            db_cnt_q[c] <= '0;
                        end else begin
                            db_cnt_q[c] <= db_cnt_q[c] + ONE;
                        end
                    end
                    PRS: begin
                        if (!s[c]) begin
                            state_q[c]  <= WAIT_R;
                            db_cnt_q[c] <= ONE;
                        end
                    end
                    WAIT_R: begin
                        if (s[c]) begin
                            state_q[c]  <= PRS;
                            db_cnt_q[c] <= '0;
                        end else if (db_cnt_q[c] == DB_LAST) begin
                            state_q[c]  <= REL;
                            db_cnt_q[c] <= '0;
                        end else begin
                            db_cnt_q[c] <= db_cnt_q[c] + ONE;
                        end
                    end
                    default: begin
                        state_q[c]  <= REL;
                        db_cnt_q[c] <= '0;
                    end
                endcase
            end
        end
    end

    // Decode the pressed-side states into the next level of each channel.
    always_comb begin
        level_d = '0;
        for (int c = 0; c < 3; c++) begin
            level_d[c] = (state_q[c] == PRS) || (state_q[c] == WAIT_R);
        end
    end

    assign press = level_d & ~level_q;

    // Repeat timing runs only while the channel was and stays pressed and
    // the opposite direction was not held; otherwise the counter is cleared,
    // so a release of the other button restarts the full repeat delay.
    assign other_q    = {level_q[0], level_q[1]};
    assign rep_active = level_q[1:0] & level_d[1:0] & ~other_q;

    // A repeat fires when the counter reaches the delay (first) or period.
    always_comb begin
        rep_fire = '0;
        for (int c = 0; c < 2; c++) begin
            rep_fire[c] = rep_active[c] &&
                (rep_cnt_q[c] == (rep_armed_q[c] ? PER_LAST : DLY_LAST));
        end
    end

    // Auto-repeat counters for right and left.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                rep_cnt_q[c] <= '0;
            end
            rep_armed_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (!rep_active[c]) begin
                    rep_cnt_q[c]   <= '0;
                    rep_armed_q[c] <= 1'b0;
                end else if (rep_fire[c]) begin
                    rep_cnt_q[c]   <= '0;
                    rep_armed_q[c] <= 1'b1;
                end else begin
                    rep_cnt_q[c] <= rep_cnt_q[c] + ONE;
                end
            end
        end
    end

    // Registered levels and pulses; a pulse accompanies the rising level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            pulse_q <= '0;
        end else begin
            level_q <= level_d;
            pulse_q <= {press[2], press[1:0] | rep_fire};
        end
    end

    assign bus.right_level = level_q[0];
    assign bus.left_level  = level_q[1];
    assign bus.ready_level = level_q[2];
    assign bus.right_pulse = pulse_q[0];
    assign bus.left_pulse  = pulse_q[1];
    assign bus.ready_pulse = pulse_q[2];
    assign bus.move_dir    = {level_q[1] & ~level_q[0], level_q[0] & ~level_q[1]};
    assign bus.dbg_state   = {state_q[2], state_q[1], state_q[0]};

endmodule

// File: tb/tb_pong_input_conditioner.sv
// Bench for pong_input_conditioner with short debounce/repeat timings.
// The reference model works from the button history: a level flips when
// the last DB synchronised samples all disagree with it, and repeats fall
// at fixed offsets from the start of an uninterrupted single-direction hold.
module tb_pong_input_conditioner;

    localparam int DB  = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pong_input_conditioner_if bus ();
    pong_input_conditioner_if bus_h ();

    pong_input_conditioner #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER),
        .INPUT_ACTIVE_LOW(1'b1), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    pong_input_conditioner #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER),
        .INPUT_ACTIVE_LOW(1'b0), .CNT_W(8)
    ) dut_h (
        .clk(clk), .reset(reset), .bus(bus_h)
    );

    // Reference model state; index 0 = right, 1 = left, 2 = ready.
    logic [15:0] hist [3];   // pressed samples, bit 0 = newest edge
    logic [2:0]  slev;       // debounced decision, one edge ahead of the outputs
    logic [2:0]  lvl;
    logic [2:0]  lvl_prev;
    logic [2:0]  pls;
    int          run [2];    // edges of uninterrupted single-direction hold

    task automatic model_reset();
        for (int c = 0; c < 3; c++) hist[c] = '0;
        slev = '0; lvl = '0; lvl_prev = '0; pls = '0;
        run[0] = 0; run[1] = 0;
    endtask

    task automatic model_edge();
        logic [2:0]    p;
        logic [DB-1:0] win;
        logic [1:0]    rep;
        p = ~{bus.ready_raw, bus.left_raw, bus.right_raw};
        lvl_prev = lvl;
        lvl      = slev;
        for (int c = 0; c < 3; c++) begin
            hist[c] = {hist[c][14:0], p[c]};
            win = hist[c][DB+1:2];
            if (!slev[c] && (&win)) slev[c] = 1'b1;
            else if (slev[c] && !(|win)) slev[c] = 1'b0;
        end
        rep = '0;
        for (int c = 0; c < 2; c++) begin
            if (lvl[c] && run[c] >= DLY && ((run[c] - DLY) % PER) == 0) rep[c] = 1'b1;
        end
        for (int c = 0; c < 2; c++) begin
            if (lvl[c] && !lvl[1-c]) run[c] = run[c] + 1;
            else run[c] = 0;
        end
        pls = (lvl & ~lvl_prev) | {1'b0, rep};
    endtask

    function automatic logic [7:0] exp_vec();
        return {lvl, pls, lvl[1] & ~lvl[0], lvl[0] & ~lvl[1]};
    endfunction

    function automatic logic [7:0] obs();
        return {bus.ready_level, bus.left_level, bus.right_level,
                bus.ready_pulse, bus.left_pulse, bus.right_pulse, bus.move_dir};
    endfunction

    // One clock edge: model follows the edge, outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.right_raw = 1'b1; bus.left_raw = 1'b1; bus.ready_raw = 1'b1;
        bus_h.right_raw = 1'b0; bus_h.left_raw = 1'b0; bus_h.ready_raw = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 8'h00 || bus.dbg_state !== 6'h00) begin
            errors++;
            $display("FAIL reset_state: got %b dbg %h expected 00000000 dbg 00", obs(), bus.dbg_state);
        end
        reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle edge %0d: got %b expected %b", n, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_ready_press();
        int first_p = -1;
        int np = 0;
        int fall = -1;
        bus.ready_raw = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.ready_pulse) begin np++; if (first_p < 0) first_p = n; end
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL ready_hold edge %0d: got %b expected %b", n, obs(), exp_vec());
            end
        end
        checks++;
        if (first_p !== DB + 2 || np !== 1) begin
            errors++;
            $display("FAIL ready_pulse_edge: got edge %0d count %0d expected edge %0d count 1", first_p, np, DB + 2);
        end
        bus.ready_raw = 1'b1;
        np = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (bus.ready_pulse) np++;
            if (!bus.ready_level && fall < 0) fall = n;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL ready_release edge %0d: got %b expected %b", n, obs(), exp_vec());
            end
        end
        checks++;
        if (fall !== DB + 2 || np !== 0) begin
            errors++;
            $display("FAIL ready_release_edge: got edge %0d pulses %0d expected edge %0d pulses 0", fall, np, DB + 2);
        end
    endtask

    task automatic test_bounce();
        int np = 0;
        int rise = -1;
        bus.right_raw = 1'b0;
        for (int n = 0; n < 11; n++) begin
            if (n == DB - 1) bus.right_raw = 1'b1;
            tick();
            if (bus.right_pulse || bus.right_level) np++;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL bounce edge %0d: got %b expected %b", n, obs(), exp_vec());
            end
        end
        checks++;
        if (np !== 0) begin
            errors++;
            $display("FAIL bounce_quiet: got %0d active cycles expected 0", np);
        end
        bus.right_raw = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (bus.right_level && rise < 0) rise = n;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL bounce_hold edge %0d: got %b expected %b", n, obs(), exp_vec());
            end
        end
        checks++;
        if (rise !== DB + 2) begin
            errors++;
            $display("FAIL bounce_rise_edge: got %0d expected %0d", rise, DB + 2);
        end
        bus.right_raw = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_repeat();
        logic [7:0] exp_q [$];
        logic [7:0] got_q [$];
        exp_q.push_back(8'(DB + 2));
        for (int t = DB + 2 + DLY; t < 40; t += PER) exp_q.push_back(8'(t));
        bus.left_raw = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus.left_pulse) got_q.push_back(8'(n));
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL repeat_hold edge %0d: got %b expected %b", n, obs(), exp_vec());
            end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL repeat_count: got %0d pulses expected %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g;
            logic [7:0] e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL repeat_edge: got %0d expected %0d", g, e);
            end
        end
        bus.left_raw = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL repeat_release edge %0d: got %b expected %b", n, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_both();
        int fall = -1;
        int first_rep = -1;
        bus.right_raw = 1'b0;
        for (int n = 0; n < 77; n++) begin
            if (n == 5)  bus.left_raw  = 1'b0;
            if (n == 35) bus.right_raw = 1'b1;
            if (n == 65) bus.left_raw  = 1'b1;
            tick();
            if (!bus.right_level && n > 20 && fall < 0) fall = n;
            if (fall >= 0 && first_rep < 0 && bus.left_pulse) first_rep = n;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL both_held edge %0d: got %b expected %b", n, obs(), exp_vec());
            end
        end
        checks++;
        if (fall !== 35 + DB + 2 || first_rep - fall !== DLY) begin
            errors++;
            $display("FAIL both_restart: got fall %0d gap %0d expected fall %0d gap %0d",
                     fall, first_rep - fall, 35 + DB + 2, DLY);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int pe [$];
        bus.right_raw = 1'b0;
        repeat (20) tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %b expected 00000000", obs());
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.right_pulse) pe.push_back(n);
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL post_reset edge %0d: got %b expected %b", n, obs(), exp_vec());
            end
        end
        checks++;
        if (pe.size() < 2 || pe[0] != DB + 2 || pe[1] != DB + 2 + DLY) begin
            errors++;
            $display("FAIL post_reset_pulses: got %0d pulses first %0d expected first %0d second %0d",
                     pe.size(), (pe.size() > 0) ? pe[0] : -1, DB + 2, DB + 2 + DLY);
        end
        bus.right_raw = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_active_high();
        logic [1:0] e;
        for (int n = 0; n < 12; n++) begin
            tick();
            checks++;
            if ({bus_h.right_level, bus_h.left_level, bus_h.ready_level,
                 bus_h.right_pulse, bus_h.left_pulse, bus_h.ready_pulse} !== 6'b0) begin
                errors++;
                $display("FAIL high_idle edge %0d: got active output expected none", n);
            end
        end
        bus_h.right_raw = 1'b1;
        for (int n = 0; n < 19; n++) begin
            tick();
            e = {n >= DB + 2, n == DB + 2 || n == DB + 2 + DLY};
            checks++;
            if ({bus_h.right_level, bus_h.right_pulse} !== e) begin
                errors++;
                $display("FAIL high_press edge %0d: got level/pulse %b expected %b",
                         n, {bus_h.right_level, bus_h.right_pulse}, e);
            end
        end
        bus_h.right_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int hold [3];
        for (int c = 0; c < 3; c++) hold[c] = $urandom_range(1, 30);
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < 3; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    case (c)
                        0: bus.right_raw = ~bus.right_raw;
                        1: bus.left_raw  = ~bus.left_raw;
                        default: bus.ready_raw = ~bus.ready_raw;
                    endcase
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DB) : $urandom_range(1, 40);
                end
            end
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL random edge %0d: got %b expected %b", n, obs(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ready_press();
        test_bounce();
        test_repeat();
        test_both();
        test_reset_mid_repeat();
        test_active_high();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pong_input_conditioner.md
Name: pong_input_conditioner

Overview:
- Input front end for the pong game. Sits between the raw DE2 push-buttons and pong_main.
- For each of right, left and ready it synchronises, debounces and normalises polarity, then produces a clean level and a one-cycle press pulse.
- Right/left pulses auto-repeat while held, and a resolved paddle direction code is produced for pong_main.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (20 ms @ 50 MHz); must be >= 2.
- REPEAT_DELAY, 25000000, cycles from a right/left press pulse to the first repeat pulse (500 ms); must be >= 2.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (100 ms); must be >= 2.
- INPUT_ACTIVE_LOW, 1, 1 = raw input low means pressed (DE2 KEY); 0 = active-high.
- CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock (50 MHz); the block's only clock.
- reset  in  1  asynchronous, active-high reset.
- right_raw  in  1  raw right button, asynchronous to clk.
- left_raw  in  1  raw left button, asynchronous to clk.
- ready_raw  in  1  raw ready/serve button, asynchronous to clk.
- right_level  out  1  debounced right, 1 = pressed.
- left_level  out  1  debounced left, 1 = pressed.
- ready_level  out  1  debounced ready, 1 = pressed.
- right_pulse  out  1  one-cycle pulse on press and on each auto-repeat.
- left_pulse  out  1  one-cycle pulse on press and on each auto-repeat.
- ready_pulse  out  1  one-cycle pulse on press only; ready never auto-repeats.
- move_dir  out  2  00 = none, 01 = right, 10 = left; 11 is never driven.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - Sync flops, counters and debounce FSMs go to released state, whatever the raw inputs are doing.
  - A button held through reset is reported as a fresh press after the normal debounce latency.
- Synchroniser: two flops per input. When INPUT_ACTIVE_LOW = 1, inversion happens after the second flop, giving a normalised sample s (1 = pressed).
- Debounce FSM, one per channel, states REL, WAIT_P, PRS, WAIT_R:
  - REL: s = 1 -> WAIT_P, counter cleared to 1.
  - WAIT_P: s = 0 -> REL, counter cleared. s = 1 and counter = DEBOUNCE_CYCLES-1 -> PRS. Otherwise counter increments.
  - PRS: s = 0 -> WAIT_R, counter cleared to 1.
  - WAIT_R: s = 1 -> PRS, counter cleared. s = 0 and counter = DEBOUNCE_CYCLES-1 -> REL. Otherwise counter increments.
  - level = 1 in PRS and WAIT_R; level = 0 in REL and WAIT_P. Levels are registered.
- Latency: edge 0 is the first clk edge sampling a new, steady raw value. Level changes at edge DEBOUNCE_CYCLES+2. Glitches shorter than DEBOUNCE_CYCLES cycles never change the level.
- Press pulse: high for exactly the one cycle after level rises (same edge as the level). Nothing is emitted on release.
- Auto-repeat (right/left only):
  - A per-channel repeat counter starts at the press pulse.
  - First repeat pulse comes REPEAT_DELAY cycles after the press pulse; later ones every REPEAT_PERIOD cycles while the level stays 1.
  - Level falling clears the counter immediately; no further pulses.
- Both directions held (right_level & left_level):
  - move_dir = 00.
  - Both repeat counters held cleared, so no repeat pulses.
  - Press pulses are still emitted.
  - When one is released, the remaining held channel restarts its repeat timing from zero: first repeat REPEAT_DELAY cycles after the release edge.
- move_dir is combinational from the registered levels: {left_level & ~right_level, right_level & ~left_level}.
- Pulse outputs are registered; at most one pulse per channel per cycle; channels are fully independent.
- Reset asserted mid-debounce or mid-repeat: all state is discarded with no trailing pulse. After release, a still-held button goes through full debounce again.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, INPUT_ACTIVE_LOW=1):
1. Hold ready_raw=0 from edge 0 -> ready_level=1 and ready_pulse=1 at edge 6. Pulse is exactly 1 cycle; no further pulses while held. Release -> ready_level=0 at the 6th edge after release, with no pulse.
2. right_raw low for 3 cycles, then high (bounce) -> right_level stays 0 and right_pulse never asserts. Then hold low -> level rises 6 edges after the final falling edge is first sampled.
3. Hold left_raw low for 40 cycles -> left_pulse at press edge P, then P+10, P+13, P+16, ...; move_dir=10 throughout. Release -> pulses stop; move_dir=00 after debounce.
4. Hold right, then press left 5 cycles later -> move_dir goes 01 then 00. left_pulse fires once; no repeat pulses while both are held. Release right -> move_dir=10 after debounce; first left repeat 10 cycles after right_level falls.
5. Assert reset while right is held, mid-repeat -> all outputs 0 immediately (async). Release reset with right still held -> right_pulse reappears 6 edges after release, then repeats resume at +10.
6. INPUT_ACTIVE_LOW=0, raw idle low -> no pulses. Raw high steady -> press pulse at edge 6.
